// File: rtl/gray_to_binary_pipe.sv
// gray_to_binary_pipe: two-stage pipelined Gray-to-binary decoder with
// valid/ready handshaking on both sides and full backpressure.
// Optional feature macro: GRAY_STEP_CHECK_EN -- when defined, accepted words
// are compared with the previous accepted word and flagged (step_err) when
// they differ in two or more bits; flagged transfers are counted in err_cnt.
// When undefined, step_err and err_cnt are tied to zero.
module gray_to_binary_pipe #(
  parameter int unsigned N         = 4,
  parameter int unsigned ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         gray_in,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [N-1:0]         binary_out,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 step_err,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  // Prefix XOR from the MSB down recovers the binary value.
  function automatic logic [N-1:0] gray2bin(input logic [N-1:0] g);
    logic [N-1:0] b;
    b = '0;
    b[N-1] = g[N-1];
    for (int i = int'(N) - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Handshake qualifiers.
  logic accept_c;
  logic s2_load_c;
  logic out_xfer_c;

  logic         s1_valid_q, s1_valid_d;
  logic [N-1:0] s1_gray_q,  s1_gray_d;
  logic         s2_valid_q, s2_valid_d;
  logic [N-1:0] s2_bin_q,   s2_bin_d;

  assign in_ready   = !s1_valid_q || !s2_valid_q || out_ready;
  assign accept_c   = in_valid && in_ready;
  assign s2_load_c  = s1_valid_q && (!s2_valid_q || out_ready);
  assign out_xfer_c = s2_valid_q && out_ready;

  assign out_valid  = s2_valid_q;
  assign binary_out = s2_bin_q;

  // Stage 1 / stage 2 next-state: S1 captures on accept, S2 captures from S1.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_gray_d  = s1_gray_q;
    s2_valid_d = s2_valid_q;
    s2_bin_d   = s2_bin_q;
    if (accept_c) begin
      s1_valid_d = 1'b1;
      s1_gray_d  = gray_in;
    end else if (s2_load_c) begin
      s1_valid_d = 1'b0;
    end
    if (s2_load_c) begin
      s2_valid_d = 1'b1;
      s2_bin_d   = gray2bin(s1_gray_q);
    end else if (out_xfer_c) begin
      s2_valid_d = 1'b0;
    end
  end

  // Pipeline data/valid registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_gray_q  <= '0;
      s2_valid_q <= 1'b0;
      s2_bin_q   <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_gray_q  <= s1_gray_d;
      s2_valid_q <= s2_valid_d;
      s2_bin_q   <= s2_bin_d;
    end
  end

`ifdef GRAY_STEP_CHECK_EN

  // True when the difference word has two or more bits set.
  function automatic logic multi_bit(input logic [N-1:0] x);
    return (x != '0) && ((x & (x - N'(1))) != '0);
  endfunction

  logic                 hist_valid_q, hist_valid_d;
  logic [N-1:0]         hist_q,       hist_d;
  logic                 s1_flag_q,    s1_flag_d;
  logic                 s2_flag_q,    s2_flag_d;
  logic [ERR_CNT_W-1:0] err_cnt_q,    err_cnt_d;
  logic                 step_bad_c;

  assign step_bad_c = hist_valid_q && multi_bit(gray_in ^ hist_q);
  assign step_err   = s2_flag_q;
  assign err_cnt    = err_cnt_q;

  // Step check at accept time; history follows every accepted word.
  always_comb begin
    hist_valid_d = hist_valid_q;
    hist_d       = hist_q;
    s1_flag_d    = s1_flag_q;
    s2_flag_d    = s2_flag_q;
    err_cnt_d    = err_cnt_q;
    if (accept_c) begin
      hist_valid_d = 1'b1;
      hist_d       = gray_in;
      s1_flag_d    = step_bad_c;
    end
    if (s2_load_c) begin
      s2_flag_d = s1_flag_q;
    end
    if (out_xfer_c && s2_flag_q && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
    end
  end

  // Checker state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_valid_q <= 1'b0;
      hist_q       <= '0;
      s1_flag_q    <= 1'b0;
      s2_flag_q    <= 1'b0;
      err_cnt_q    <= '0;
    end else begin
      hist_valid_q <= hist_valid_d;
      hist_q       <= hist_d;
      s1_flag_q    <= s1_flag_d;
      s2_flag_q    <= s2_flag_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

`else

  // Checker removed: status outputs are constant zero.
  assign step_err = 1'b0;
  assign err_cnt  = '0;

`endif

endmodule

// File: tb/tb_gray_to_binary_pipe.sv
// Directed self-checking bench for gray_to_binary_pipe (N=4, ERR_CNT_W=8).
module tb_gray_to_binary_pipe;

`ifdef GRAY_STEP_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic [3:0] gray_in;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] binary_out;
  logic       out_valid;
  logic       out_ready;
  logic       step_err;
  logic [7:0] err_cnt;

  int checks = 0;
  int errors = 0;

  gray_to_binary_pipe #(.N(4), .ERR_CNT_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .gray_in    (gray_in),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .binary_out (binary_out),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .step_err   (step_err),
    .err_cnt    (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    gray_in   = 4'b0000;
    out_ready = 1'b1;
    rst_n     = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  // Drive one word for a single cycle (caller guarantees in_ready).
  task automatic push_word(input logic [3:0] g);
    in_valid = 1'b1;
    gray_in  = g;
    step();
    in_valid = 1'b0;
  endtask

  // Wait (bounded) until out_valid is high; returns whether it was seen.
  task automatic wait_out(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid === 1'b1) begin
        seen = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic test_reset();
    in_valid  = 1'b0;
    gray_in   = 4'b0000;
    out_ready = 1'b0;
    rst_n     = 1'b0;
    #12;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || binary_out !== 4'b0000 ||
        step_err !== 1'b0 || err_cnt !== 8'd0) begin
      errors++;
      $display("FAIL reset_values: in_ready=%b out_valid=%b binary_out=%b step_err=%b err_cnt=%0d, required 1 0 0000 0 0",
               in_ready, out_valid, binary_out, step_err, err_cnt);
    end
    out_ready = 1'b1;
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_back_to_back();
    logic [3:0] words [5] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110};
    do_reset();
    for (int c = 0; c < 7; c++) begin
      if (c < 5) begin
        in_valid = 1'b1;
        gray_in  = words[c];
      end else begin
        in_valid = 1'b0;
      end
      step();
      if (c >= 1 && c <= 5) begin
        checks++;
        if (out_valid !== 1'b1 || binary_out !== 4'(c - 1) || step_err !== 1'b0) begin
          errors++;
          $display("FAIL b2b_word%0d: out_valid=%b binary_out=%b step_err=%b, required 1 %b 0",
                   c - 1, out_valid, binary_out, step_err, 4'(c - 1));
        end
      end else if (c == 6) begin
        checks++;
        if (out_valid !== 1'b0) begin
          errors++;
          $display("FAIL b2b_drained: out_valid=%b, required 0", out_valid);
        end
      end
    end
    checks++;
    if (err_cnt !== 8'd0) begin
      errors++;
      $display("FAIL b2b_err_cnt: err_cnt=%0d, required 0", err_cnt);
    end
  endtask

  task automatic test_single_words();
    bit seen;
    do_reset();
    push_word(4'b0110);
    wait_out(seen);
    checks++;
    if (!seen || binary_out !== 4'b0100 || step_err !== 1'b0) begin
      errors++;
      $display("FAIL single_0110: seen=%0d binary_out=%b step_err=%b, required 1 0100 0", seen, binary_out, step_err);
    end
    // 1000 differs from 0110 in three bits.
    push_word(4'b1000);
    wait_out(seen);
    checks++;
    if (!seen || binary_out !== 4'b1111 || step_err !== CHK) begin
      errors++;
      $display("FAIL single_1000: seen=%0d binary_out=%b step_err=%b, required 1 1111 %b", seen, binary_out, step_err, CHK);
    end
    step();
    checks++;
    if (err_cnt !== 8'(CHK)) begin
      errors++;
      $display("FAIL single_err_cnt: err_cnt=%0d, required %0d", err_cnt, CHK);
    end
  endtask

  task automatic test_step_flag();
    bit seen;
    do_reset();
    push_word(4'b0000);
    wait_out(seen);
    checks++;
    if (!seen || binary_out !== 4'b0000 || step_err !== 1'b0) begin
      errors++;
      $display("FAIL step_first: seen=%0d binary_out=%b step_err=%b, required 1 0000 0", seen, binary_out, step_err);
    end
    push_word(4'b0011);
    wait_out(seen);
    checks++;
    if (!seen || binary_out !== 4'b0010 || step_err !== CHK) begin
      errors++;
      $display("FAIL step_bad: seen=%0d binary_out=%b step_err=%b, required 1 0010 %b", seen, binary_out, step_err, CHK);
    end
    step();
    checks++;
    if (err_cnt !== 8'(CHK)) begin
      errors++;
      $display("FAIL step_err_cnt1: err_cnt=%0d, required %0d", err_cnt, CHK);
    end
    push_word(4'b0011);
    wait_out(seen);
    checks++;
    if (!seen || binary_out !== 4'b0010 || step_err !== 1'b0) begin
      errors++;
      $display("FAIL step_repeat: seen=%0d binary_out=%b step_err=%b, required 1 0010 0", seen, binary_out, step_err);
    end
    step();
    checks++;
    if (err_cnt !== 8'(CHK)) begin
      errors++;
      $display("FAIL step_err_cnt2: err_cnt=%0d, required %0d", err_cnt, CHK);
    end
  endtask

  task automatic test_stall();
    logic [3:0] words [6] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111};
    logic [3:0] got [$];
    int  idx = 0;
    bit  acc, xfer;
    do_reset();
    for (int cyc = 0; cyc < 40 && got.size() < 6; cyc++) begin
      out_ready = !(cyc >= 1 && cyc <= 5);
      in_valid  = (idx < 6);
      gray_in   = (idx < 6) ? words[idx] : 4'b1111;
      #1;
      if (cyc >= 2 && cyc <= 5) begin
        checks++;
        if (out_valid !== 1'b1 || binary_out !== 4'b0000 || in_ready !== 1'b0) begin
          errors++;
          $display("FAIL stall_cyc%0d: out_valid=%b binary_out=%b in_ready=%b, required 1 0000 0",
                   cyc, out_valid, binary_out, in_ready);
        end
      end
      xfer = out_valid && out_ready;
      acc  = in_valid && in_ready;
      if (xfer) begin
        got.push_back(binary_out);
        checks++;
        if (step_err !== 1'b0) begin
          errors++;
          $display("FAIL stall_step_err: step_err=%b on word %0d, required 0", step_err, got.size() - 1);
        end
      end
      if (acc) idx++;
      step();
    end
    in_valid = 1'b0;
    checks++;
    if (got.size() != 6) begin
      errors++;
      $display("FAIL stall_count: received %0d words, required 6", got.size());
    end
    for (int i = 0; i < got.size() && i < 6; i++) begin
      checks++;
      if (got[i] !== 4'(i)) begin
        errors++;
        $display("FAIL stall_order%0d: binary_out=%b, required %b", i, got[i], 4'(i));
      end
    end
    step();
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_no_dup: out_valid=%b after drain, required 0", out_valid);
    end
  endtask

  // Alternating 0000/0011 words: every word after the first is a 2-bit step.
  task automatic feed_alt(input int n, input bit start_phase, output bit end_phase);
    bit ph = start_phase;
    out_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      gray_in  = ph ? 4'b0011 : 4'b0000;
      ph = !ph;
      step();
    end
    in_valid = 1'b0;
    step();
    step();
    step();
    end_phase = ph;
  endtask

  task automatic test_saturation();
    bit ph;
    do_reset();
    feed_alt(101, 1'b0, ph);
    checks++;
    if (err_cnt !== (CHK ? 8'd100 : 8'd0)) begin
      errors++;
      $display("FAIL sat_mid: err_cnt=%0d, required %0d", err_cnt, CHK ? 100 : 0);
    end
    feed_alt(200, ph, ph);
    checks++;
    if (err_cnt !== (CHK ? 8'd255 : 8'd0)) begin
      errors++;
      $display("FAIL sat_final: err_cnt=%0d, required %0d", err_cnt, CHK ? 255 : 0);
    end
  endtask

  task automatic test_reset_midstream();
    bit seen;
    do_reset();
    out_ready = 1'b0;
    push_word(4'b0000);
    push_word(4'b0001);
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_full: out_valid=%b in_ready=%b, required 1 0", out_valid, in_ready);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || binary_out !== 4'b0000 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_async: out_valid=%b binary_out=%b in_ready=%b, required 0 0000 1",
               out_valid, binary_out, in_ready);
    end
    step();
    rst_n = 1'b1;
    out_ready = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_dropped: out_valid=%b after release, required 0", out_valid);
    end
    // 1111 is three bits away from the pre-reset 0001, but history is invalid.
    push_word(4'b1111);
    wait_out(seen);
    checks++;
    if (!seen || binary_out !== 4'b1010 || step_err !== 1'b0) begin
      errors++;
      $display("FAIL mid_first: seen=%0d binary_out=%b step_err=%b, required 1 1010 0", seen, binary_out, step_err);
    end
    step();
    checks++;
    if (err_cnt !== 8'd0) begin
      errors++;
      $display("FAIL mid_err_cnt: err_cnt=%0d, required 0", err_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_single_words();
    test_step_flag();
    test_stall();
    test_saturation();
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
